i2c_byte_writer: RTL
====================

// Module: i2c_byte_writer
// PURPOSE
//  Write-only I2C master. Sends one data byte per request to a fixed 7-bit slave:
//  START, address+W, ACK, data, ACK, STOP. Sits directly downstream of the LCD opcode
//  sequencer, which drives i_i2c_en/i_i2c_sdata and waits for o_i2c_busy to fall.
//  Target: PCF8574 backpack of the 2004A LCD.
// PARAMETERS
//  CLK_DIV     125    i_clk cycles per SCL quarter-period; 50 MHz -> 100 kHz SCL; legal >= 2
//  SLAVE_ADDR  7'h27  7-bit slave address; R/W bit is always 0
// PORTS
//  i_clk        in   1  system clock, all logic on rising edge
//  i_rst        in   1  synchronous active-high reset
//  i_i2c_en     in   1  active-low request; a high->low transition starts one transfer
//  i_i2c_sdata  in   8  data byte, latched when the request is accepted
//  i_i2c_sda    in   1  sampled SDA line, used only for ACK checks
//  o_i2c_scl    out  1  SCL drive; 1 = release (high)
//  o_i2c_sda    out  1  SDA drive; 1 = release (high), 0 = pull low
//  o_i2c_busy   out  1  high from the cycle after acceptance until STOP completes
//  o_ack_err    out  1  sticky: a NACK was seen in the current/last transfer
// BEHAVIOUR
//  Reset values: o_i2c_scl=1, o_i2c_sda=1, o_i2c_busy=0, o_ack_err=0, state IDLE.
//    The en-edge register resets to 1.
//  Request detection:
//    - Register i_i2c_en each cycle; edge = prev==1 && cur==0.
//    - Edges are accepted only in IDLE. Edges seen while busy are discarded, not queued.
//    - Holding i_i2c_en low starts exactly one transfer.
//  Acceptance (cycle N):
//    - Latch shift reg = {SLAVE_ADDR,1'b0}. Latch data reg = i_i2c_sdata.
//    - Clear o_ack_err. Enter START. o_i2c_busy=1 from N+1.
//  Timing: each slot is 4 quarters q0..q3, each CLK_DIV cycles, using a quarter counter
//    0..CLK_DIV-1 and a 2-bit quarter index.
//  States and line values:
//    IDLE : SCL=1, SDA=1.
//    START: SCL=1 for q0..q3; SDA=1 in q0-q1, SDA=0 in q2-q3.
//    ADDR, DATA: 8 slots each, MSB first.
//      - SDA changes only at the start of q0.
//      - SCL=0 in q0-q1, SCL=1 in q2-q3.
//    ACK1, ACK2: 1 slot each.
//      - SDA released (1); SCL as for data bits.
//      - i_i2c_sda sampled on the last cycle of q2; if 1, set o_ack_err.
//      - A NACK does NOT abort; the transfer always runs to STOP.
//    STOP: SCL=0 in q0-q1, SCL=1 in q2-q3; SDA=0 in q0..q2, SDA=1 in q3.
//  Slot sequence: START, ADDR (8 slots), ACK1, DATA (8 slots), ACK2, STOP.
//    - 20 slots total.
//    - o_i2c_busy is high for exactly 80*CLK_DIV cycles, then IDLE.
//    - The next edge is accepted in the first IDLE cycle at the earliest.
//  i_i2c_sdata may change freely after acceptance; the latched copy is used.
//  Reset mid-transfer: on the next edge all outputs return to reset values and
//    in-flight data is discarded. The bus may see a truncated frame; this is accepted.
//  Counter widths: $clog2(CLK_DIV) for the quarter counter, 3-bit bit index.
//    Counters wrap only under state control, never free-running.
// TESTING
//  1 Hold i_rst=1 for 3 cycles with i_i2c_en=0
//      -> SCL=1, SDA=1, busy=0, ack_err=0. No transfer starts while in reset.
//  2 CLK_DIV=4, SLAVE_ADDR=7'h27, i_i2c_sdata=8'hA5, ACKs driven 0, one en fall
//      -> decoded bytes 8'h4E, 8'hA5. START/STOP seen on SDA while SCL=1.
//      -> busy high exactly 320 cycles. ack_err=0.
//  3 As 2 but i_i2c_sda held 1 during ACK2
//      -> full frame incl. STOP, ack_err=1 after busy falls.
//      -> next accepted request clears ack_err at acceptance.
//  4 i_i2c_en held low for 1000 cycles after one fall -> exactly one frame (320 busy cycles).
//  5 Second en fall and sdata=8'h3C mid-transfer
//      -> ignored; the frame still carries 8'hA5; no second frame.
//  6 i_rst pulse during DATA bit 3 -> next cycle SCL=1, SDA=1, busy=0.
//      -> a new request afterwards produces a correct full frame.

Source files
------------

// File: rtl/i2c_byte_writer.sv
// Write-only I2C master: one START / addr+W / ACK / data / ACK / STOP frame per
// falling edge of the active-low request, to a fixed 7-bit slave address.
module i2c_byte_writer #(
  parameter int         CLK_DIV    = 125,
  parameter logic [6:0] SLAVE_ADDR = 7'h27
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_i2c_en,
  input  logic [7:0] i_i2c_sdata,
  input  logic       i_i2c_sda,
  output logic       o_i2c_scl,
  output logic       o_i2c_sda,
  output logic       o_i2c_busy,
  output logic       o_ack_err
);

  localparam int QW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ACK1, DATA, ACK2, STOP
  } state_t;

  state_t        state_reg, state_next;
  logic          en_prev_reg;
  logic [QW-1:0] qcnt_reg;
  logic [1:0]    quarter_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    data_reg;
  logic          ack_err_reg;

  logic req_edge;
  logic q_end;
  logic slot_end;
  logic is_ack;

  assign req_edge = en_prev_reg & ~i_i2c_en;
  assign q_end    = (qcnt_reg == QW'(CLK_DIV - 1));
  assign slot_end = q_end && (quarter_reg == 2'd3);
  assign is_ack   = (state_reg == ACK1) || (state_reg == ACK2);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_edge) state_next = START;
      START:   if (slot_end) state_next = ADDR;
      ADDR:    if (slot_end && bit_reg == 3'd7) state_next = ACK1;
      ACK1:    if (slot_end) state_next = DATA;
      DATA:    if (slot_end && bit_reg == 3'd7) state_next = ACK2;
      ACK2:    if (slot_end) state_next = STOP;
      STOP:    if (slot_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Timing counters, shifter and ACK status; counters only run outside IDLE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_prev_reg <= 1'b1;
      qcnt_reg    <= '0;
      quarter_reg <= 2'd0;
      bit_reg     <= 3'd0;
      shift_reg   <= 8'd0;
      data_reg    <= 8'd0;
      ack_err_reg <= 1'b0;
    end else begin
      en_prev_reg <= i_i2c_en;
      if (state_reg == IDLE) begin
        qcnt_reg    <= '0;
        quarter_reg <= 2'd0;
        bit_reg     <= 3'd0;
        if (req_edge) begin
          shift_reg   <= {SLAVE_ADDR, 1'b0};
          data_reg    <= i_i2c_sdata;
          ack_err_reg <= 1'b0;
        end
      end else begin
        if (q_end) begin
          qcnt_reg    <= '0;
          quarter_reg <= quarter_reg + 2'd1;
        end else begin
          qcnt_reg <= qcnt_reg + QW'(1);
        end
        if (slot_end && (state_reg == ADDR || state_reg == DATA)) begin
          bit_reg   <= bit_reg + 3'd1;
          shift_reg <= {shift_reg[6:0], 1'b0};
        end
        if (slot_end && state_reg == ACK1) begin
          shift_reg <= data_reg;
        end
        // Slave drives ACK while SCL is high; sample at the end of q2
        if (is_ack && quarter_reg == 2'd2 && q_end && i_i2c_sda) begin
          ack_err_reg <= 1'b1;
        end
      end
    end
  end

  // Output decode
  always_comb begin
    o_i2c_scl  = 1'b1;
    o_i2c_sda  = 1'b1;
    o_i2c_busy = (state_reg != IDLE);
    o_ack_err  = ack_err_reg;
    case (state_reg)
      START: o_i2c_sda = ~quarter_reg[1];
      ADDR, DATA: begin
        o_i2c_scl = quarter_reg[1];
        o_i2c_sda = shift_reg[7];
      end
      ACK1, ACK2: o_i2c_scl = quarter_reg[1];
      STOP: begin
        o_i2c_scl = quarter_reg[1];
        o_i2c_sda = (quarter_reg == 2'd3);
      end
      default: ;
    endcase
  end

endmodule
